// File: rtl/uart_frame_pkg.sv
// Shared constants for the host-link framers: delimiters, deframer state encoding and the
// error codes reported alongside err_pulse.
package uart_frame_pkg;

    localparam logic [7:0] START_BYTE_DEF = 8'hF0;
    localparam logic [7:0] STOP_BYTE_DEF  = 8'h0F;

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CSUM    = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FRAMING = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte stream in, frame and error reports out. The byte source and frame consumer form the
// master side; the deframer is the slave.
interface uart_frame_rx_if #(
    parameter int unsigned PAYLOAD_BYTES = 16
);
    logic [7:0]                   byte_in;
    logic                         byte_dv;
    logic                         frame_dv;
    logic [7:0]                   frame_addr;
    logic [8*PAYLOAD_BYTES-1:0]   frame_payload;
    logic                         err_pulse;
    logic [1:0]                   err_code;

    modport master (
        output byte_in, byte_dv,
        input  frame_dv, frame_addr, frame_payload, err_pulse, err_code
    );

    modport slave (
        input  byte_in, byte_dv,
        output frame_dv, frame_addr, frame_payload, err_pulse, err_code
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment wins.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/uart_frame_rx.sv
// Receive deframer: hunts for START, gathers address + payload (+ XOR checksum), checks STOP,
// and publishes whole frames. Outputs keep the last good frame across errors and timeouts.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES  = 16,
    parameter logic [7:0]  START_BYTE     = START_BYTE_DEF,
    parameter logic [7:0]  STOP_BYTE      = STOP_BYTE_DEF,
    parameter bit          CSUM_EN        = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    uart_frame_rx_if.slave   link_io,
    input  logic             err_clr_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt_ok_o,
    output logic [CNT_W-1:0] cnt_framing_o,
    output logic [CNT_W-1:0] cnt_csum_o,
    output logic [CNT_W-1:0] cnt_timeout_o
);
    localparam int unsigned IdxW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned PayW = 8 * PAYLOAD_BYTES;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(PAYLOAD_BYTES - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic       byte_dv;
    logic [7:0] byte_in;

    logic [2:0]      state_q, state_d;
    logic [7:0]      addr_sh_q, addr_sh_d;
    logic [PayW-1:0] shadow_q, shadow_d;
    logic [7:0]      csum_q, csum_d;
    logic            bad_csum_q, bad_csum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic            frame_dv_q;
    logic [7:0]      frame_addr_q, frame_addr_d;
    logic [PayW-1:0] frame_payload_q, frame_payload_d;
    logic            err_pulse_q;
    logic [1:0]      err_code_q, err_code_d;

    logic tmo_expire;
    logic ok_evt, framing_evt, csum_evt, err_evt;

    assign byte_dv = link_io.byte_dv;
    assign byte_in = link_io.byte_in;

    // A byte arriving on the expiry cycle keeps the frame alive.
    assign tmo_expire = (TIMEOUT_CYCLES != 0) && (state_q != ST_HUNT) && !byte_dv &&
                        (tmo_q == TmoLast);

    always_comb begin
        if ((TIMEOUT_CYCLES == 0) || byte_dv || (state_q == ST_HUNT)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_sh_d   = addr_sh_q;
        shadow_d    = shadow_q;
        csum_d      = csum_q;
        bad_csum_d  = bad_csum_q;
        idx_d       = idx_q;
        ok_evt      = 1'b0;
        framing_evt = 1'b0;
        csum_evt    = 1'b0;
        if (tmo_expire) begin
            state_d = ST_HUNT;
        end else if (byte_dv) begin
            case (state_q)
                ST_HUNT: begin
                    if (byte_in == START_BYTE) begin
                        state_d    = ST_ADDR;
                        csum_d     = '0;
                        bad_csum_d = 1'b0;
                    end
                end
                ST_ADDR: begin
                    addr_sh_d = byte_in;
                    csum_d    = csum_q ^ byte_in;
                    idx_d     = '0;
                    state_d   = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    shadow_d[{idx_q, 3'b000} +: 8] = byte_in;
                    csum_d = csum_q ^ byte_in;
                    if (idx_q == LastIdx) begin
                        state_d = CSUM_EN ? ST_CSUM : ST_STOP;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                ST_CSUM: begin
                    bad_csum_d = (byte_in != csum_q);
                    state_d    = ST_STOP;
                end
                ST_STOP: begin
                    if (byte_in == STOP_BYTE) begin
                        ok_evt   = !bad_csum_q;
                        csum_evt = bad_csum_q;
                        state_d  = ST_HUNT;
                    end else begin
                        // A bad stop outranks a bad checksum; a START here opens a new frame.
                        framing_evt = 1'b1;
                        if (byte_in == START_BYTE) begin
                            state_d    = ST_ADDR;
                            csum_d     = '0;
                            bad_csum_d = 1'b0;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    assign err_evt = framing_evt | csum_evt | tmo_expire;

    always_comb begin
        frame_addr_d    = ok_evt ? addr_sh_q : frame_addr_q;
        frame_payload_d = ok_evt ? shadow_q : frame_payload_q;
        if (tmo_expire) begin
            err_code_d = ERR_TIMEOUT;
        end else if (framing_evt) begin
            err_code_d = ERR_FRAMING;
        end else if (csum_evt) begin
            err_code_d = ERR_CSUM;
        end else begin
            err_code_d = ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_HUNT;
            addr_sh_q       <= '0;
            shadow_q        <= '0;
            csum_q          <= '0;
            bad_csum_q      <= 1'b0;
            idx_q           <= '0;
            tmo_q           <= '0;
            frame_dv_q      <= 1'b0;
            frame_addr_q    <= '0;
            frame_payload_q <= '0;
            err_pulse_q     <= 1'b0;
            err_code_q      <= ERR_NONE;
        end else begin
            state_q         <= state_d;
            addr_sh_q       <= addr_sh_d;
            shadow_q        <= shadow_d;
            csum_q          <= csum_d;
            bad_csum_q      <= bad_csum_d;
            idx_q           <= idx_d;
            tmo_q           <= tmo_d;
            frame_dv_q      <= ok_evt;
            frame_addr_q    <= frame_addr_d;
            frame_payload_q <= frame_payload_d;
            err_pulse_q     <= err_evt;
            err_code_q      <= err_code_d;
        end
    end

    assign link_io.frame_dv      = frame_dv_q;
    assign link_io.frame_addr    = frame_addr_q;
    assign link_io.frame_payload = frame_payload_q;
    assign link_io.err_pulse     = err_pulse_q;
    assign link_io.err_code      = err_code_q;
    assign busy_o                = (state_q != ST_HUNT);

    sat_counter #(.WIDTH(CNT_W)) u_cnt_ok (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (ok_evt),
        .clr_i   (err_clr_i),
        .count_o (cnt_ok_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt_framing (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (framing_evt),
        .clr_i   (err_clr_i),
        .count_o (cnt_framing_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt_csum (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (csum_evt),
        .clr_i   (err_clr_i),
        .count_o (cnt_csum_o)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (tmo_expire),
        .clr_i   (err_clr_i),
        .count_o (cnt_timeout_o)
    );
endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed vector table, hand sequences for timeout/reset/saturation,
// and random frames checked against a queue-based frame model.
module tb_uart_frame_rx;
    localparam int unsigned PB   = 16;
    localparam int unsigned TMO  = 64;
    localparam int unsigned FLEN = PB + 3;
    localparam logic [7:0]  SB   = 8'hF0;
    localparam logic [7:0]  EB   = 8'h0F;
    localparam logic [127:0] P1  = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [127:0] PC0 = 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic err_clr = 1'b0;
    logic busy_a, busy_b;
    logic [15:0] ok_a, fr_a, cs_a, to_a;
    logic [1:0]  ok_b, fr_b, cs_b, to_b;

    uart_frame_rx_if #(.PAYLOAD_BYTES(PB)) if_a ();
    uart_frame_rx_if #(.PAYLOAD_BYTES(PB)) if_b ();

    uart_frame_rx #(.PAYLOAD_BYTES(PB), .CSUM_EN(1'b1), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .link_io(if_a), .err_clr_i(err_clr), .busy_o(busy_a),
        .cnt_ok_o(ok_a), .cnt_framing_o(fr_a), .cnt_csum_o(cs_a), .cnt_timeout_o(to_a)
    );

    uart_frame_rx #(.PAYLOAD_BYTES(PB), .CSUM_EN(1'b1), .TIMEOUT_CYCLES(TMO), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .link_io(if_b), .err_clr_i(err_clr), .busy_o(busy_b),
        .cnt_ok_o(ok_b), .cnt_framing_o(fr_b), .cnt_csum_o(cs_b), .cnt_timeout_o(to_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: bytes since START are queued and judged once the frame is complete.
    bit          m_in_frame;
    logic [7:0]  m_q[$];
    int          m_idle;
    logic [7:0]  m_addr;
    logic [127:0] m_pl;
    bit          m_dv, m_err;
    logic [1:0]  m_code;
    int          m_ok, m_fr, m_cs, m_to;

    typedef struct {
        bit          dv;
        logic [7:0]  b;
        bit          e_dv;
        bit          e_err;
        logic [1:0]  e_code;
        bit          chk;
        logic [7:0]  e_addr;
        logic [127:0] e_pl;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic mdl_reset();
        m_in_frame = 0; m_q.delete(); m_idle = 0;
        m_addr = '0; m_pl = '0; m_dv = 0; m_err = 0; m_code = '0;
        m_ok = 0; m_fr = 0; m_cs = 0; m_to = 0;
    endtask

    task automatic mdl_step(input bit dv, input logic [7:0] b, input bit clr);
        logic [7:0] x;
        m_dv = 0; m_err = 0; m_code = '0;
        if (dv) begin
            m_idle = 0;
            if (!m_in_frame) begin
                if (b == SB) begin m_in_frame = 1; m_q.delete(); end
            end else begin
                m_q.push_back(b);
                if (m_q.size() == FLEN) begin
                    x = '0;
                    for (int k = 0; k <= PB; k++) x ^= m_q[k];
                    m_in_frame = 0;
                    if (b != EB) begin
                        m_err = 1; m_code = 2'd1; m_fr++;
                        if (b == SB) m_in_frame = 1;
                    end else if (m_q[PB+1] != x) begin
                        m_err = 1; m_code = 2'd2; m_cs++;
                    end else begin
                        m_dv = 1; m_ok++; m_addr = m_q[0];
                        for (int k = 0; k < PB; k++) m_pl = {m_q[k+1], m_pl[127:8]};
                    end
                    m_q.delete();
                end
            end
        end else if (m_in_frame) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_in_frame = 0; m_err = 1; m_code = 2'd3; m_to++; m_q.delete();
            end
        end
        if (clr) begin m_ok = 0; m_fr = 0; m_cs = 0; m_to = 0; end
    endtask

    task automatic check_all();
        chk("a.frame_dv", if_a.frame_dv, m_dv);
        chk("a.err_pulse", if_a.err_pulse, m_err);
        if (m_err) chk("a.err_code", if_a.err_code, m_code);
        chk("a.frame_addr", if_a.frame_addr, m_addr);
        chk("a.frame_payload", if_a.frame_payload, m_pl);
        chk("a.busy", busy_a, m_in_frame);
        chk("a.cnt_ok", ok_a, sat(m_ok, 16));
        chk("a.cnt_framing", fr_a, sat(m_fr, 16));
        chk("a.cnt_csum", cs_a, sat(m_cs, 16));
        chk("a.cnt_timeout", to_a, sat(m_to, 16));
        chk("b.frame_dv", if_b.frame_dv, m_dv);
        chk("b.frame_addr", if_b.frame_addr, m_addr);
        chk("b.busy", busy_b, m_in_frame);
        chk("b.cnt_ok", ok_b, sat(m_ok, 2));
        chk("b.cnt_framing", fr_b, sat(m_fr, 2));
        chk("b.cnt_csum", cs_b, sat(m_cs, 2));
        chk("b.cnt_timeout", to_b, sat(m_to, 2));
    endtask

    task automatic drive(input bit dv, input logic [7:0] b, input bit clr);
        if_a.byte_dv = dv; if_a.byte_in = b;
        if_b.byte_dv = dv; if_b.byte_in = b;
        err_clr = clr;
        mdl_step(dv, b, clr);
        @(posedge clk);
        #1;
        check_all();
        if_a.byte_dv = 1'b0; if_b.byte_dv = 1'b0; err_clr = 1'b0;
    endtask

    task automatic rdrive(input bit dv, input logic [7:0] b);
        drive(dv, b, $urandom_range(0, 39) == 0);
    endtask

    task automatic send_frame(input logic [7:0] addr, input logic [7:0] base,
                              input logic [7:0] mask, input logic [7:0] stop, input bit clr_last);
        logic [7:0] x, d;
        drive(1, SB, 0);
        drive(1, addr, 0);
        x = addr;
        for (int k = 0; k < PB; k++) begin
            d = base + 8'(k); x ^= d; drive(1, d, 0);
        end
        drive(1, x ^ mask, 0);
        drive(1, stop, clr_last);
    endtask

    task automatic add_vec(input bit dv, input logic [7:0] b, input bit edv, input bit eerr,
                           input logic [1:0] ecode, input bit c, input logic [7:0] eaddr,
                           input logic [127:0] epl);
        vec_t v;
        v.dv = dv; v.b = b; v.e_dv = edv; v.e_err = eerr; v.e_code = ecode;
        v.chk = c; v.e_addr = eaddr; v.e_pl = epl;
        vecs.push_back(v);
    endtask

    task automatic add_body(input logic [7:0] addr, input logic [7:0] base, input logic [7:0] mask,
                            input logic [7:0] stop, input bit edv, input bit eerr,
                            input logic [1:0] ecode, input bit c, input logic [7:0] eaddr,
                            input logic [127:0] epl);
        logic [7:0] x, d;
        add_vec(1, addr, 0, 0, 2'd0, 0, 8'h0, '0);
        x = addr;
        for (int k = 0; k < PB; k++) begin
            d = base + 8'(k); x ^= d; add_vec(1, d, 0, 0, 2'd0, 0, 8'h0, '0);
        end
        add_vec(1, x ^ mask, 0, 0, 2'd0, 0, 8'h0, '0);
        add_vec(1, stop, edv, eerr, ecode, c, eaddr, epl);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fb [0:FLEN];
        logic [7:0] x;
        int kind;

        if_a.byte_dv = 1'b0; if_a.byte_in = '0;
        if_b.byte_dv = 1'b0; if_b.byte_in = '0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.frame_dv", if_a.frame_dv, 1'b0);
        chk("reset.err_pulse", if_a.err_pulse, 1'b0);
        chk("reset.busy", busy_a, 1'b0);
        chk("reset.frame_payload", if_a.frame_payload, 128'h0);
        chk("reset.cnt_ok", ok_a, 16'h0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: good, bad checksum, resync, noise, back-to-back, precedence.
        add_vec(1, SB, 0, 0, 2'd0, 0, 8'h0, '0);
        add_body(8'h05, 8'h01, 8'h00, EB, 1, 0, 2'd0, 1, 8'h05, P1);
        add_vec(1, SB, 0, 0, 2'd0, 0, 8'h0, '0);
        add_body(8'h05, 8'h01, 8'h01, EB, 0, 1, 2'd2, 1, 8'h05, P1);
        add_vec(1, SB, 0, 0, 2'd0, 0, 8'h0, '0);
        add_body(8'h05, 8'h01, 8'h00, SB, 0, 1, 2'd1, 1, 8'h05, P1);
        add_body(8'h33, 8'h40, 8'h00, EB, 1, 0, 2'd0, 0, 8'h33, '0);
        add_vec(0, 8'h00, 0, 0, 2'd0, 0, 8'h0, '0);
        add_vec(1, 8'h00, 0, 0, 2'd0, 0, 8'h0, '0);
        add_vec(1, 8'hAA, 0, 0, 2'd0, 0, 8'h0, '0);
        add_vec(1, 8'h0F, 0, 0, 2'd0, 0, 8'h0, '0);
        add_vec(1, SB, 0, 0, 2'd0, 0, 8'h0, '0);
        add_body(8'h11, 8'h80, 8'h00, EB, 1, 0, 2'd0, 0, 8'h11, '0);
        add_vec(1, SB, 0, 0, 2'd0, 0, 8'h0, '0);
        add_body(8'h22, 8'hC0, 8'h00, EB, 1, 0, 2'd0, 1, 8'h22, PC0);
        add_vec(1, SB, 0, 0, 2'd0, 0, 8'h0, '0);
        add_body(8'h44, 8'h02, 8'hFF, 8'h00, 0, 1, 2'd1, 1, 8'h22, PC0);

        foreach (vecs[i]) begin
            drive(vecs[i].dv, vecs[i].b, 0);
            chk($sformatf("tbl[%0d].frame_dv", i), if_a.frame_dv, vecs[i].e_dv);
            chk($sformatf("tbl[%0d].err_pulse", i), if_a.err_pulse, vecs[i].e_err);
            if (vecs[i].e_err) chk($sformatf("tbl[%0d].err_code", i), if_a.err_code, vecs[i].e_code);
            if (vecs[i].chk) begin
                chk($sformatf("tbl[%0d].frame_addr", i), if_a.frame_addr, vecs[i].e_addr);
                chk($sformatf("tbl[%0d].frame_payload", i), if_a.frame_payload, vecs[i].e_pl);
            end
        end
        chk("tbl.cnt_ok", ok_a, 16'd4);
        chk("tbl.cnt_ok_sat", ok_b, 2'd3);
        chk("tbl.cnt_framing", fr_a, 16'd2);
        chk("tbl.cnt_csum", cs_a, 16'd1);

        // Timeout after 64 byte-less cycles.
        drive(1, SB, 0); drive(1, 8'h05, 0); drive(1, 8'h01, 0);
        repeat (TMO - 1) drive(0, 8'h00, 0);
        chk("tmo.busy_before", busy_a, 1'b1);
        chk("tmo.no_pulse_early", if_a.err_pulse, 1'b0);
        drive(0, 8'h00, 0);
        chk("tmo.err_pulse", if_a.err_pulse, 1'b1);
        chk("tmo.err_code", if_a.err_code, 2'd3);
        chk("tmo.busy_after", busy_a, 1'b0);
        chk("tmo.cnt_timeout", to_a, 16'd1);

        // A byte on the 64th cycle keeps the frame alive.
        drive(1, SB, 0); drive(1, 8'h05, 0); drive(1, 8'h01, 0);
        repeat (TMO - 1) drive(0, 8'h00, 0);
        drive(1, 8'h02, 0);
        chk("tmo_save.err_pulse", if_a.err_pulse, 1'b0);
        chk("tmo_save.busy", busy_a, 1'b1);
        repeat (TMO) drive(0, 8'h00, 0);
        chk("tmo_save.cnt_timeout", to_a, 16'd2);

        // Reset mid-payload.
        drive(1, SB, 0); drive(1, 8'h05, 0); drive(1, 8'h01, 0); drive(1, 8'h02, 0);
        reset_n = 1'b0;
        #1;
        chk("rst.busy", busy_a, 1'b0);
        chk("rst.frame_addr", if_a.frame_addr, 8'h0);
        chk("rst.frame_payload", if_a.frame_payload, 128'h0);
        chk("rst.err_pulse", if_a.err_pulse, 1'b0);
        chk("rst.cnt_ok", ok_a, 16'h0);
        chk("rst.cnt_timeout", to_a, 16'h0);
        mdl_reset();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) drive(0, 8'h00, 0);

        // Saturation and clear-wins-over-increment.
        repeat (5) send_frame(8'h07, 8'h10, 8'h00, 8'h00, 0);
        chk("sat.cnt_framing_a", fr_a, 16'd5);
        chk("sat.cnt_framing_b", fr_b, 2'd3);
        send_frame(8'h07, 8'h10, 8'h00, 8'h00, 1);
        chk("clr.cnt_framing_a", fr_a, 16'd0);
        chk("clr.cnt_framing_b", fr_b, 2'd0);
        chk("clr.err_pulse", if_a.err_pulse, 1'b1);

        // Random frames with corruption, noise, gaps, timeouts and sporadic clears.
        for (int f = 0; f < 150; f++) begin
            kind = int'($urandom_range(0, 9));
            repeat ($urandom_range(0, 2)) rdrive(0, 8'h00);
            if ($urandom_range(0, 3) == 0) rdrive(1, 8'($urandom_range(0, 255)));
            fb[0] = SB;
            fb[1] = 8'($urandom_range(0, 255));
            x = fb[1];
            for (int k = 0; k < PB; k++) begin
                fb[2+k] = 8'($urandom_range(0, 255));
                x ^= fb[2+k];
            end
            fb[PB+2] = (kind == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
            fb[PB+3] = (kind == 1) ? 8'($urandom_range(0, 255)) : ((kind == 2) ? SB : EB);
            for (int k = 0; k <= FLEN; k++) begin
                if (kind == 3 && k == 8) begin
                    repeat (TMO + $urandom_range(0, 3)) rdrive(0, 8'h00);
                end else if ($urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(1, 5)) rdrive(0, 8'h00);
                end
                rdrive(1, fb[k]);
            end
        end
        repeat (TMO + 2) drive(0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Parametrised receive deframer for the host link. It consumes the byte stream from the UART byte receiver and hunts for a start delimiter. It captures an address byte and PAYLOAD_BYTES payload bytes in strict LSB-first order, optionally checks an XOR checksum, verifies the stop delimiter, and delivers the whole frame as one bus to the algo mux. It adds behaviour the previous deframer lacked: inter-byte timeout, resync on a start byte, hold-last-good outputs, and saturating error counters.

Parameters:
PAYLOAD_BYTES, 16, number of payload bytes per frame (>=1); byte k lands in frame_payload[8k+7:8k]
START_BYTE, 8'hF0, start delimiter
STOP_BYTE, 8'h0F, stop delimiter
CSUM_EN, 1, 1 = a checksum byte sits between the last payload byte and STOP
TIMEOUT_CYCLES, 100000, maximum clk cycles between bytes inside a frame; 0 disables the timeout
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
byte_in  in  8  received byte, valid when byte_dv=1
byte_dv  in  1  one-cycle strobe from the UART byte receiver
err_clr  in  1  synchronous clear of all four counters
frame_dv  out  1  one-cycle pulse: new frame on frame_addr/frame_payload
frame_addr  out  8  address of the last good frame
frame_payload  out  8*PAYLOAD_BYTES  payload of the last good frame
busy  out  1  high while state != HUNT
err_pulse  out  1  one-cycle pulse on any rejected frame
err_code  out  2  0 none, 1 framing (bad stop), 2 checksum, 3 timeout; valid with err_pulse
cnt_ok, cnt_framing, cnt_csum, cnt_timeout  out  CNT_W each  saturating event counters

Behaviour:
- Reset:
  - state=HUNT; all outputs 0; shadow registers, checksum and timeout counter 0.
  - Reset asserted mid-frame discards the partial frame with no error pulse.
- Checksum: csum = XOR of the address byte and every payload byte. It is cleared on entry to ADDR.
- State machine; all transitions require byte_dv except timeout:
  - HUNT: byte==START_BYTE -> ADDR. Any other byte is ignored silently.
  - ADDR: latch addr_sh, csum^=byte, idx=0 -> PAYLOAD.
  - PAYLOAD: shadow[8*idx+:8]=byte, csum^=byte. If idx==PAYLOAD_BYTES-1, go to CSUM when CSUM_EN=1, else STOP; otherwise idx++.
  - CSUM: bad_csum = (byte != csum) -> STOP.
  - STOP, byte==STOP_BYTE and !bad_csum: commit. frame_addr<=addr_sh, frame_payload<=shadow, frame_dv=1 and cnt_ok++ on the next cycle -> HUNT.
  - STOP, byte==STOP_BYTE and bad_csum: err_code=2, cnt_csum++ -> HUNT.
  - STOP, byte!=STOP_BYTE: err_code=1, cnt_framing++. If byte==START_BYTE, go to ADDR (resync, csum cleared); otherwise -> HUNT. Framing takes precedence over a checksum error.
- Latency: frame_dv and err_pulse assert exactly 1 cycle after the byte_dv cycle of the deciding byte. Both are single-cycle pulses.
- Outputs on error: frame_addr/frame_payload hold the last good values and are never zeroed. Partially written shadow bytes are never visible on the outputs.
- Timeout:
  - tmo counter clears on every byte_dv and increments each cycle while state != HUNT.
  - When it reaches TIMEOUT_CYCLES with no byte_dv: -> HUNT, err_code=3, cnt_timeout++.
  - If byte_dv arrives in the same cycle the count would expire, the byte wins and no timeout occurs.
  - The counter does not run in HUNT.
- Counters saturate at 2^CNT_W-1. If err_clr coincides with an increment, err_clr wins and the counter becomes 0.
- Back-to-back frames with zero idle cycles between STOP and the next START are accepted; there is no dead cycle.

Decomposition:
- Package uart_frame_pkg holds:
  - the state enum (HUNT, ADDR, PAYLOAD, CSUM, STOP)
  - err_code constants (ERR_NONE, ERR_FRAMING, ERR_CSUM, ERR_TIMEOUT)
  - default START_BYTE/STOP_BYTE constants, shared with the future TX framer
- Sub-module sat_counter (WIDTH param; inc, clr inputs; clr priority) is instantiated four times.

Test Plan:
1. Good frame. PAYLOAD_BYTES=16, CSUM_EN=1. Send F0, 05, 01..10, 15, 0F -> frame_dv=1 one cycle after 0F; frame_addr=05; frame_payload=128'h100F0E0D0C0B0A090807060504030201; cnt_ok=1.
2. Bad checksum. Same frame with checksum byte 14 -> err_pulse, err_code=2, cnt_csum=1, frame_payload unchanged from scenario 1, no frame_dv.
3. Resync. F0, 05, 16 payload bytes, checksum 15, then F0 instead of 0F, followed immediately by a good frame body -> err_code=1 pulse, then the second frame is delivered; cnt_framing=1, cnt_ok=+1.
4. Timeout. TIMEOUT_CYCLES=64. Send F0, 05, 01, then idle -> err_code=3 exactly 64 cycles after the last byte_dv; busy=0. A byte arriving on cycle 64 instead prevents the timeout.
5. Noise and back-to-back. Send 00, AA, 0F in HUNT -> no pulses, counters unchanged. Then two good frames with no gap -> two frame_dv pulses, cnt_ok=+2.
6. Reset and saturation. Assert reset_n low mid-PAYLOAD -> all outputs 0, state HUNT. With CNT_W=2, send 5 bad-stop frames -> cnt_framing=3. Then err_clr -> 0.
